// File: rtl/axi_ram_pkg.sv
// Shared constants and FSM encodings for the AXI4 RAM slave.
package axi_ram_pkg;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {WS_IDLE = 2'd0, WS_DATA = 2'd1, WS_RESP = 2'd2} wr_state_t;
  typedef enum logic [1:0] {RS_IDLE = 2'd0, RS_FETCH = 2'd1, RS_DATA = 2'd2} rd_state_t;
endpackage

// File: rtl/axi_ram_slave_if.sv
// AXI4 full bus bundle between the HLS master and the RAM slave.
interface axi_ram_slave_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 64,
  parameter int ID_WIDTH   = 1,
  parameter int USER_WIDTH = 1
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                  AWVALID, AWREADY;
  logic [ADDR_WIDTH-1:0] AWADDR;
  logic [ID_WIDTH-1:0]   AWID;
  logic [7:0]            AWLEN;
  logic [2:0]            AWSIZE;
  logic [1:0]            AWBURST;
  logic [1:0]            AWLOCK;
  logic [3:0]            AWCACHE;
  logic [2:0]            AWPROT;
  logic [3:0]            AWQOS;
  logic [3:0]            AWREGION;
  logic [USER_WIDTH-1:0] AWUSER;

  logic                  WVALID, WREADY;
  logic [DATA_WIDTH-1:0] WDATA;
  logic [STRB_WIDTH-1:0] WSTRB;
  logic                  WLAST;
  logic [ID_WIDTH-1:0]   WID;
  logic [USER_WIDTH-1:0] WUSER;

  logic                  BVALID, BREADY;
  logic [ID_WIDTH-1:0]   BID;
  logic [1:0]            BRESP;
  logic [USER_WIDTH-1:0] BUSER;

  logic                  ARVALID, ARREADY;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [ID_WIDTH-1:0]   ARID;
  logic [7:0]            ARLEN;
  logic [2:0]            ARSIZE;
  logic [1:0]            ARBURST;
  logic [1:0]            ARLOCK;
  logic [3:0]            ARCACHE;
  logic [2:0]            ARPROT;
  logic [3:0]            ARQOS;
  logic [3:0]            ARREGION;
  logic [USER_WIDTH-1:0] ARUSER;

  logic                  RVALID, RREADY;
  logic [DATA_WIDTH-1:0] RDATA;
  logic [ID_WIDTH-1:0]   RID;
  logic [1:0]            RRESP;
  logic                  RLAST;
  logic [USER_WIDTH-1:0] RUSER;

  modport slave (
    input  AWVALID, AWADDR, AWID, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWQOS, AWREGION, AWUSER,
    output AWREADY,
    input  WVALID, WDATA, WSTRB, WLAST, WID, WUSER,
    output WREADY,
    output BVALID, BID, BRESP, BUSER,
    input  BREADY,
    input  ARVALID, ARADDR, ARID, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS, ARREGION, ARUSER,
    output ARREADY,
    output RVALID, RDATA, RID, RRESP, RLAST, RUSER,
    input  RREADY
  );

  modport master (
    output AWVALID, AWADDR, AWID, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWQOS, AWREGION, AWUSER,
    input  AWREADY,
    output WVALID, WDATA, WSTRB, WLAST, WID, WUSER,
    input  WREADY,
    input  BVALID, BID, BRESP, BUSER,
    output BREADY,
    output ARVALID, ARADDR, ARID, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS, ARREGION, ARUSER,
    input  ARREADY,
    input  RVALID, RDATA, RID, RRESP, RLAST, RUSER,
    output RREADY
  );
endinterface

// File: rtl/axi_ram_mem.sv
// Simple dual-port RAM: byte-enabled write port, registered read port (read-first).
module axi_ram_mem #(
  parameter int DATA_WIDTH = 128,
  parameter int WORD_BITS  = 12
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [WORD_BITS-1:0]    waddr,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic                    re,
  input  logic [WORD_BITS-1:0]    raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);
  logic [DATA_WIDTH-1:0] mem [2**WORD_BITS];

  // rdata only moves on re so a stalled read beat keeps its data
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
    if (we)
      for (int b = 0; b < DATA_WIDTH/8; b++)
        if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
  end
endmodule

// File: rtl/axi_ram_slave.sv
// AXI4 slave memory model: independent write/read FSMs over one byte-enabled RAM.
// Build option AXI_RAM_STALL_EN adds LFSR-driven ready/response stalls.
import axi_ram_pkg::*;

module axi_ram_slave #(
  parameter int DATA_WIDTH    = 128,
  parameter int ADDR_WIDTH    = 64,
  parameter int ID_WIDTH      = 1,
  parameter int USER_WIDTH    = 1,
  parameter int MEM_ADDR_BITS = 16
) (
  input logic            clk,
  input logic            rst,
  axi_ram_slave_if.slave s_axi
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int SB         = $clog2(STRB_WIDTH);
  localparam int WORD_BITS  = MEM_ADDR_BITS - SB;
  localparam logic [2:0]            FULL_SIZE = 3'(SB);
  localparam logic [ADDR_WIDTH-1:0] STEP      = ADDR_WIDTH'(STRB_WIDTH);

  localparam logic [1:0] W_IDLE  = WS_IDLE;
  localparam logic [1:0] W_DATA  = WS_DATA;
  localparam logic [1:0] W_RESP  = WS_RESP;
  localparam logic [1:0] R_IDLE  = RS_IDLE;
  localparam logic [1:0] R_FETCH = RS_FETCH;
  localparam logic [1:0] R_DATA  = RS_DATA;

  function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
    return (a >> MEM_ADDR_BITS) != '0;
  endfunction

  logic stall_rdy, stall_dly;
`ifdef AXI_RAM_STALL_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk)
    if (rst) lfsr <= 16'hACE1;
    else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign stall_rdy = lfsr[0];
  assign stall_dly = lfsr[1];
`else
  assign stall_rdy = 1'b0;
  assign stall_dly = 1'b0;
`endif

  // ---------------- write channel ----------------
  logic [1:0]            w_state;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]            w_len, w_cnt;
  logic [ID_WIDTH-1:0]   w_id;
  logic [1:0]            w_burst;
  logic                  w_err, w_fin;
  logic                  aw_rdy, w_rdy, b_vld, aw_hs, w_hs, w_last_beat, w_oor;

  assign aw_rdy      = !rst && (w_state == W_IDLE) && !stall_rdy;
  assign w_rdy       = !rst && (w_state == W_DATA) && !w_fin && !stall_rdy;
  assign b_vld       = !rst && (w_state == W_RESP);
  assign aw_hs       = s_axi.AWVALID && aw_rdy;
  assign w_hs        = s_axi.WVALID && w_rdy;
  assign w_last_beat = (w_cnt == w_len);
  assign w_oor       = out_of_range(w_addr);

  assign s_axi.AWREADY = aw_rdy;
  assign s_axi.WREADY  = w_rdy;
  assign s_axi.BVALID  = b_vld;
  assign s_axi.BID     = b_vld ? w_id : '0;
  assign s_axi.BRESP   = (b_vld && w_err) ? RESP_SLVERR : RESP_OKAY;
  assign s_axi.BUSER   = '0;

  // Burst length is owned by the counter; WLAST only feeds the error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      w_fin   <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (aw_hs) begin
          w_addr  <= {s_axi.AWADDR[ADDR_WIDTH-1:SB], SB'(0)};
          w_len   <= s_axi.AWLEN;
          w_id    <= s_axi.AWID;
          w_burst <= s_axi.AWBURST;
          w_cnt   <= '0;
          w_err   <= (s_axi.AWSIZE != FULL_SIZE) || (s_axi.AWBURST == BURST_WRAP);
          w_state <= W_DATA;
        end
        W_DATA: if (w_fin) begin
          w_fin   <= 1'b0;
          w_state <= W_RESP;
        end else if (w_hs) begin
          if (w_burst != BURST_FIXED) w_addr <= w_addr + STEP;
          if (w_oor || (s_axi.WLAST != w_last_beat)) w_err <= 1'b1;
          if (w_last_beat) begin
            if (stall_dly) w_fin   <= 1'b1;
            else           w_state <= W_RESP;
          end else begin
            w_cnt <= w_cnt + 8'd1;
          end
        end
        W_RESP: if (s_axi.BREADY) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // ---------------- read channel ----------------
  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_addr, r_next;
  logic [7:0]            r_len, r_cnt;
  logic [ID_WIDTH-1:0]   r_id;
  logic [1:0]            r_burst;
  logic                  r_err, r_dly;
  logic                  ar_rdy, r_vld, ar_hs, r_hs, r_last, r_oor;
  logic                  mem_re;
  logic [WORD_BITS-1:0]  mem_raddr;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign ar_rdy = !rst && (r_state == R_IDLE) && !stall_rdy;
  assign r_vld  = !rst && (r_state == R_DATA);
  assign ar_hs  = s_axi.ARVALID && ar_rdy;
  assign r_hs   = r_vld && s_axi.RREADY;
  assign r_last = (r_cnt == r_len);
  assign r_oor  = out_of_range(r_addr);
  assign r_next = (r_burst == BURST_FIXED) ? r_addr : r_addr + STEP;

  // Prefetch the next word on the accepting edge so beats stream one per cycle
  assign mem_re    = (r_state == R_FETCH) || (r_hs && !r_last);
  assign mem_raddr = (r_state == R_FETCH) ? r_addr[MEM_ADDR_BITS-1:SB] : r_next[MEM_ADDR_BITS-1:SB];

  assign s_axi.ARREADY = ar_rdy;
  assign s_axi.RVALID  = r_vld;
  assign s_axi.RDATA   = (r_vld && !r_oor) ? mem_rdata : '0;
  assign s_axi.RID     = r_vld ? r_id : '0;
  assign s_axi.RRESP   = (r_vld && (r_err || r_oor)) ? RESP_SLVERR : RESP_OKAY;
  assign s_axi.RLAST   = r_vld && r_last;
  assign s_axi.RUSER   = '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      r_dly   <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: if (ar_hs) begin
          r_addr  <= {s_axi.ARADDR[ADDR_WIDTH-1:SB], SB'(0)};
          r_len   <= s_axi.ARLEN;
          r_id    <= s_axi.ARID;
          r_burst <= s_axi.ARBURST;
          r_cnt   <= '0;
          r_err   <= (s_axi.ARSIZE != FULL_SIZE) || (s_axi.ARBURST == BURST_WRAP);
          r_state <= R_FETCH;
        end
        R_FETCH: if (stall_dly && !r_dly) begin
          r_dly <= 1'b1;
        end else begin
          r_dly   <= 1'b0;
          r_state <= R_DATA;
        end
        R_DATA: if (r_hs) begin
          if (r_last) begin
            r_state <= R_IDLE;
          end else begin
            r_addr <= r_next;
            r_cnt  <= r_cnt + 8'd1;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  axi_ram_mem #(.DATA_WIDTH(DATA_WIDTH), .WORD_BITS(WORD_BITS)) u_mem (
    .clk   (clk),
    .we    (w_hs && !w_oor),
    .waddr (w_addr[MEM_ADDR_BITS-1:SB]),
    .wstrb (s_axi.WSTRB),
    .wdata (s_axi.WDATA),
    .re    (mem_re),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  logic unused_ok;
  assign unused_ok = ^{s_axi.AWADDR[SB-1:0], s_axi.AWLOCK, s_axi.AWCACHE, s_axi.AWPROT, s_axi.AWQOS,
                       s_axi.AWREGION, s_axi.AWUSER, s_axi.WID, s_axi.WUSER,
                       s_axi.ARADDR[SB-1:0], s_axi.ARLOCK, s_axi.ARCACHE, s_axi.ARPROT, s_axi.ARQOS,
                       s_axi.ARREGION, s_axi.ARUSER};
endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed + randomized bench for axi_ram_slave against a byte-array reference memory.
module tb_axi_ram_slave;
  localparam int DW = 128;
  localparam int AW = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_ram_slave_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(1), .USER_WIDTH(1)) s_axi ();

  axi_ram_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(1), .USER_WIDTH(1), .MEM_ADDR_BITS(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .s_axi (s_axi)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0]   ref_mem [0:65535];
  logic [127:0] wd [256];
  logic [15:0]  ws [256];
  logic         wl [256];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: apply each beat at its byte address; flag all error rules
  task automatic model_write(input logic [63:0] addr, input int len, input logic [1:0] burst,
                             input logic [2:0] size, output logic [1:0] resp);
    logic [63:0] a;
    logic err;
    err = (size != 3'd4) || (burst == 2'b10);
    for (int i = 0; i <= len; i++) begin
      a = {addr[63:4], 4'h0} + ((burst == 2'b00) ? 64'd0 : 64'(i) * 64'd16);
      if (wl[i] != (i == len)) err = 1'b1;
      if (a >= 64'h10000) err = 1'b1;
      else for (int b = 0; b < 16; b++)
        if (ws[i][b]) ref_mem[int'(a[15:0]) + b] = wd[i][8*b +: 8];
    end
    resp = err ? 2'b10 : 2'b00;
  endtask

  function automatic logic [127:0] model_rd(input logic [63:0] a);
    logic [127:0] d = '0;
    if (a < 64'h10000)
      for (int b = 0; b < 16; b++) d[8*b +: 8] = ref_mem[int'(a[15:0]) + b];
    return d;
  endfunction

  task automatic axi_write(input string nm, input logic [63:0] addr, input int len,
                           input logic [1:0] burst, input logic [2:0] size, input logic id);
    logic [1:0] exp_resp;
    int w;
    bit w_ok;
    model_write(addr, len, burst, size, exp_resp);
    s_axi.AWADDR = addr; s_axi.AWLEN = 8'(len); s_axi.AWBURST = burst;
    s_axi.AWSIZE = size; s_axi.AWID = id; s_axi.AWVALID = 1'b1;
    for (w = 0; w < 100 && !s_axi.AWREADY; w++) begin @(posedge clk); #1; end
    chk({nm, " aw_wait"}, w < 100, 1'b1);
    @(posedge clk); #1;
    s_axi.AWVALID = 1'b0;
    w_ok = 1'b1;
    for (int i = 0; i <= len; i++) begin
      s_axi.WDATA = wd[i]; s_axi.WSTRB = ws[i]; s_axi.WLAST = wl[i]; s_axi.WVALID = 1'b1;
      for (w = 0; w < 100 && !s_axi.WREADY; w++) begin @(posedge clk); #1; end
      if (w >= 100) w_ok = 1'b0;
      @(posedge clk); #1;
    end
    s_axi.WVALID = 1'b0; s_axi.WLAST = 1'b0;
    chk({nm, " w_beats"}, w_ok, 1'b1);
    chk({nm, " wready_after_last"}, s_axi.WREADY, 1'b0);
    s_axi.BREADY = 1'b1;
    for (w = 0; w < 100 && !s_axi.BVALID; w++) begin @(posedge clk); #1; end
    chk({nm, " b_wait"}, w < 100, 1'b1);
    chk({nm, " bresp"}, s_axi.BRESP, exp_resp);
    chk({nm, " bid"}, s_axi.BID, id);
    @(posedge clk); #1;
    s_axi.BREADY = 1'b0;
  endtask

  // mode: 0 RREADY always high, 1 toggling, 2 random
  task automatic axi_read(input string nm, input logic [63:0] addr, input int len, input logic [1:0] burst,
                          input logic [2:0] size, input logic id, input int mode, input bit chk_lat);
    logic [127:0] exp_d [256];
    logic [1:0]   exp_r [256];
    logic [63:0]  a;
    logic         derr, hold, hl;
    logic [127:0] hd;
    logic [1:0]   hr;
    int beat, k, w, first_k;
    derr = (size != 3'd4) || (burst == 2'b10);
    for (int i = 0; i <= len; i++) begin
      a = {addr[63:4], 4'h0} + ((burst == 2'b00) ? 64'd0 : 64'(i) * 64'd16);
      exp_d[i] = model_rd(a);
      exp_r[i] = (derr || a >= 64'h10000) ? 2'b10 : 2'b00;
    end
    s_axi.ARADDR = addr; s_axi.ARLEN = 8'(len); s_axi.ARBURST = burst;
    s_axi.ARSIZE = size; s_axi.ARID = id; s_axi.ARVALID = 1'b1;
    for (w = 0; w < 100 && !s_axi.ARREADY; w++) begin @(posedge clk); #1; end
    chk({nm, " ar_wait"}, w < 100, 1'b1);
    @(posedge clk); #1;
    s_axi.ARVALID = 1'b0;
    beat = 0; k = 0; first_k = -1; hold = 1'b0; hd = '0; hr = '0; hl = 1'b0;
    while (beat <= len && k < 2000) begin
      case (mode)
        0:       s_axi.RREADY = 1'b1;
        1:       s_axi.RREADY = 1'(k % 2);
        default: s_axi.RREADY = 1'($urandom_range(0, 1));
      endcase
      if (chk_lat && k == 0) chk({nm, " rvalid_early"}, s_axi.RVALID, 1'b0);
      if (s_axi.RVALID && first_k < 0) first_k = k;
      if (hold)
        chk($sformatf("%s stable[%0d]", nm, beat), {s_axi.RVALID, s_axi.RDATA, s_axi.RRESP, s_axi.RLAST},
            {1'b1, hd, hr, hl});
      hold = 1'b0;
      if (s_axi.RVALID && s_axi.RREADY) begin
        chk($sformatf("%s rdata[%0d]", nm, beat), s_axi.RDATA, exp_d[beat]);
        chk($sformatf("%s rresp[%0d]", nm, beat), s_axi.RRESP, exp_r[beat]);
        chk($sformatf("%s rlast[%0d]", nm, beat), s_axi.RLAST, beat == len);
        chk($sformatf("%s rid[%0d]", nm, beat), s_axi.RID, id);
        beat++;
      end else if (s_axi.RVALID) begin
        hold = 1'b1; hd = s_axi.RDATA; hr = s_axi.RRESP; hl = s_axi.RLAST;
      end
      @(posedge clk); #1;
      k++;
    end
    s_axi.RREADY = 1'b0;
    chk({nm, " r_beats"}, beat, len + 1);
    if (chk_lat) chk({nm, " r_latency"}, first_k, 1);
  endtask

  initial begin
    logic [63:0] ra;
    int rl;
    logic [1:0] rb;
    logic [2:0] rs;
    int w;

    s_axi.AWVALID = 0; s_axi.AWADDR = '0; s_axi.AWID = '0; s_axi.AWLEN = '0; s_axi.AWSIZE = '0;
    s_axi.AWBURST = '0; s_axi.AWLOCK = '0; s_axi.AWCACHE = '0; s_axi.AWPROT = '0; s_axi.AWQOS = '0;
    s_axi.AWREGION = '0; s_axi.AWUSER = '0;
    s_axi.WVALID = 0; s_axi.WDATA = '0; s_axi.WSTRB = '0; s_axi.WLAST = 0; s_axi.WID = '0; s_axi.WUSER = '0;
    s_axi.BREADY = 0;
    s_axi.ARVALID = 0; s_axi.ARADDR = '0; s_axi.ARID = '0; s_axi.ARLEN = '0; s_axi.ARSIZE = '0;
    s_axi.ARBURST = '0; s_axi.ARLOCK = '0; s_axi.ARCACHE = '0; s_axi.ARPROT = '0; s_axi.ARQOS = '0;
    s_axi.ARREGION = '0; s_axi.ARUSER = '0;
    s_axi.RREADY = 0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst awready", s_axi.AWREADY, 1'b0);
    chk("rst arready", s_axi.ARREADY, 1'b0);
    chk("rst bvalid",  s_axi.BVALID,  1'b0);
    chk("rst rvalid",  s_axi.RVALID,  1'b0);
    rst = 1'b0;
    #1;
    chk("post-rst awready", s_axi.AWREADY, 1'b1);
    chk("post-rst arready", s_axi.ARREADY, 1'b1);

    // Known contents for 0x000-0xFFF
    for (int i = 0; i < 256; i++) begin
      wd[i] = {$urandom, $urandom, $urandom, $urandom}; ws[i] = 16'hFFFF; wl[i] = (i == 255);
    end
    axi_write("fill", 64'h0, 255, 2'b01, 3'd4, 1'b0);

    for (int i = 0; i < 4; i++) begin
      wd[i] = {4{32'(i + 1)}}; ws[i] = 16'hFFFF; wl[i] = (i == 3);
    end
    axi_write("incr", 64'h100, 3, 2'b01, 3'd4, 1'b1);
    axi_read("incr", 64'h100, 3, 2'b01, 3'd4, 1'b1, 0, 1'b1);

    wd[0] = '1; ws[0] = 16'hFFFF; wl[0] = 1'b1;
    axi_write("pfill", 64'h200, 0, 2'b01, 3'd4, 1'b0);
    wd[0] = '0; ws[0] = 16'h00F0;
    axi_write("pstrb", 64'h200, 0, 2'b01, 3'd4, 1'b0);
    chk("pstrb model", model_rd(64'h200), 128'hFFFFFFFF_FFFFFFFF_00000000_FFFFFFFF);
    axi_read("pstrb", 64'h200, 0, 2'b01, 3'd4, 1'b0, 0, 1'b0);

    for (int i = 0; i < 3; i++) begin
      wd[i] = {$urandom, $urandom, $urandom, $urandom}; ws[i] = 16'hFFFF; wl[i] = (i == 2);
    end
    axi_write("fixed", 64'h300, 2, 2'b00, 3'd4, 1'b1);
    axi_read("fixed", 64'h300, 1, 2'b01, 3'd4, 1'b1, 0, 1'b0);

    wd[0] = {4{32'hDEADBEEF}}; ws[0] = 16'hFFFF; wl[0] = 1'b1;
    axi_write("oor", 64'h1_0000, 0, 2'b01, 3'd4, 1'b0);
    axi_read("oor", 64'h1_0000, 0, 2'b01, 3'd4, 1'b0, 0, 1'b0);
    axi_read("oor alias", 64'h0, 0, 2'b01, 3'd4, 1'b0, 0, 1'b0);

    for (int i = 0; i < 2; i++) begin
      wd[i] = {$urandom, $urandom, $urandom, $urandom}; ws[i] = 16'hFFFF; wl[i] = (i == 1);
    end
    axi_write("wrap64", 64'hFFFF_FFFF_FFFF_FFF5, 1, 2'b01, 3'd4, 1'b1);
    axi_read("wrap64", 64'hFFFF_FFFF_FFFF_FFF0, 1, 2'b01, 3'd4, 1'b1, 0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      wd[i] = {$urandom, $urandom, $urandom, $urandom}; ws[i] = 16'hFFFF; wl[i] = (i == 1);
    end
    axi_write("early wlast", 64'h400, 3, 2'b01, 3'd4, 1'b0);
    axi_read("early wlast", 64'h400, 3, 2'b01, 3'd4, 1'b0, 0, 1'b0);
    axi_read("toggle", 64'h0, 15, 2'b01, 3'd4, 1'b1, 1, 1'b0);

    for (int i = 0; i < 4; i++) begin
      wd[i] = {$urandom, $urandom, $urandom, $urandom}; ws[i] = 16'(($urandom)); wl[i] = (i == 3);
    end
    axi_write("wrap burst", 64'h500, 3, 2'b10, 3'd4, 1'b0);
    axi_read("wrap burst", 64'h500, 3, 2'b10, 3'd4, 1'b0, 0, 1'b0);
    axi_read("bad size", 64'h500, 1, 2'b01, 3'd3, 1'b1, 0, 1'b0);

    repeat (8) begin
      ra = 64'($urandom_range(0, 32'h0F00));
      rl = $urandom_range(0, 15);
      rb = 2'($urandom_range(0, 2));
      rs = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd4;
      for (int i = 0; i <= rl; i++) begin
        wd[i] = {$urandom, $urandom, $urandom, $urandom};
        ws[i] = 16'($urandom);
        wl[i] = (i == rl) ^ ($urandom_range(0, 7) == 0);
      end
      axi_write("rnd", ra, rl, rb, rs, 1'($urandom));
      axi_read("rnd", ra, rl, 2'($urandom_range(0, 2)), rs, 1'($urandom), 2, 1'b0);
    end

    // Reset in the middle of a 16-beat read
    s_axi.ARADDR = 64'h0; s_axi.ARLEN = 8'd15; s_axi.ARBURST = 2'b01; s_axi.ARSIZE = 3'd4;
    s_axi.ARID = 1'b0; s_axi.ARVALID = 1'b1;
    for (w = 0; w < 100 && !s_axi.ARREADY; w++) begin @(posedge clk); #1; end
    chk("midrst ar_wait", w < 100, 1'b1);
    @(posedge clk); #1;
    s_axi.ARVALID = 1'b0; s_axi.RREADY = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("midrst rvalid before", s_axi.RVALID, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst rvalid in rst", s_axi.RVALID, 1'b0);
    chk("midrst arready in rst", s_axi.ARREADY, 1'b0);
    @(posedge clk); #1;
    chk("midrst rvalid after edge", s_axi.RVALID, 1'b0);
    rst = 1'b0; s_axi.RREADY = 1'b0;
    #1;
    chk("midrst arready release", s_axi.ARREADY, 1'b1);
    chk("midrst rvalid release", s_axi.RVALID, 1'b0);
    axi_read("after rst", 64'h100, 3, 2'b01, 3'd4, 1'b1, 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_ram_slave.md
Name: axi_ram_slave

Overview:
- AXI4 slave memory model that sits directly downstream of the HLS core's m_axi_mm_video0 master port in the cocotb top.
- Accepts the master's 64-bit-address, 128-bit-data bursts and stores write data in an internal byte-enabled RAM.
- Returns read bursts from that RAM, giving the bench a self-contained memory target instead of a Python model.
- Write and read channels are independent state machines sharing one RAM.

Parameters:
- DATA_WIDTH, 128, data bus width in bits (power of two, at least 32).
- ADDR_WIDTH, 64, address bus width.
- ID_WIDTH, 1, AXI ID width.
- USER_WIDTH, 1, width of the AxUSER/WUSER/RUSER/BUSER ports.
- MEM_ADDR_BITS, 16, RAM size is 2^MEM_ADDR_BITS bytes.
- STRB_WIDTH, DATA_WIDTH/8, derived; do not override.

Ports:
- clk  input  1  single clock.
- rst  input  1  synchronous, active-high reset.
- s_axi_AWVALID/AWREADY  in/out  1  write address handshake.
- s_axi_AWADDR  input  ADDR_WIDTH  burst start byte address.
- s_axi_AWID  input  ID_WIDTH  write ID.
- s_axi_AWLEN  input  8  beats minus 1.
- s_axi_AWSIZE  input  3  must equal log2(STRB_WIDTH).
- s_axi_AWBURST  input  2  FIXED/INCR/WRAP.
- s_axi_AWLOCK/AWCACHE/AWPROT/AWQOS/AWREGION/AWUSER  input  2/4/3/4/4/USER_WIDTH  accepted, ignored.
- s_axi_WVALID/WREADY  in/out  1  write data handshake.
- s_axi_WDATA  input  DATA_WIDTH  write data.
- s_axi_WSTRB  input  STRB_WIDTH  byte enables.
- s_axi_WLAST  input  1  last beat.
- s_axi_WID/WUSER  input  ID_WIDTH/USER_WIDTH  ignored.
- s_axi_BVALID/BREADY  out/in  1  write response handshake.
- s_axi_BID  output  ID_WIDTH  response ID.
- s_axi_BRESP  output  2  response code.
- s_axi_BUSER  output  USER_WIDTH  tied 0.
- s_axi_ARVALID/ARREADY  in/out  1  read address handshake.
- s_axi_ARADDR/ARID/ARLEN/ARSIZE/ARBURST  input  ADDR_WIDTH/ID_WIDTH/8/3/2  read burst descriptor.
- s_axi_ARLOCK/ARCACHE/ARPROT/ARQOS/ARREGION/ARUSER  input  as AW  ignored.
- s_axi_RVALID/RREADY  out/in  1  read data handshake.
- s_axi_RDATA  output  DATA_WIDTH  read data.
- s_axi_RID  output  ID_WIDTH  read ID.
- s_axi_RRESP  output  2  read response code.
- s_axi_RLAST  output  1  last read beat.
- s_axi_RUSER  output  USER_WIDTH  tied 0.

Behaviour:
- Reset: clock is clk; reset rst is synchronous, active-high.
- While rst is high: all outputs 0, both FSMs in IDLE. RAM contents are not cleared.
- Reset mid-burst abandons the burst silently.
- AWREADY and ARREADY rise in the first cycle after rst falls.
- Write FSM W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: AWREADY=1. On the AW handshake, latch the address aligned down to STRB_WIDTH, LEN, ID and BURST; clear the beat counter and error flag; go to W_DATA.
  - W_DATA: AWREADY=0, WREADY=1. Each W handshake writes bytes where WSTRB=1.
  - Address update per beat: INCR and WRAP add STRB_WIDTH; FIXED holds the address. WRAP is treated as INCR with error set.
  - Beat counter reaching LEN ends the burst; go to W_RESP.
  - WLAST asserted on a beat other than beat LEN, or deasserted on beat LEN, sets error. Termination always follows the counter.
  - W_RESP: BVALID=1, BID=latched ID, BRESP=SLVERR(2'b10) if error else OKAY(2'b00). Hold until BREADY, then W_IDLE.
  - W handshakes are only accepted after the AW handshake.
- Read FSM R_IDLE -> R_FETCH -> R_DATA:
  - R_IDLE: ARREADY=1. On the AR handshake, latch the descriptor; go to R_FETCH, which issues the synchronous RAM read.
  - R_DATA: RVALID=1, RLAST=(beat==LEN).
  - On an R handshake that is not last, advance the address and read the next word so the next beat is valid the following cycle: back-to-back, one beat per cycle.
  - On the last beat handshake, go to R_IDLE.
  - Latency: AR handshake at cycle t gives first RVALID at t+2.
  - RDATA, RID, RRESP and RLAST are stable while RVALID && !RREADY.
- Address range:
  - A beat address with any bit at or above MEM_ADDR_BITS set is out of range.
  - Out-of-range write beat: dropped, error set.
  - Out-of-range read beat: RDATA=0, RRESP=SLVERR.
  - Address arithmetic is full ADDR_WIDTH with wrap-around at 2^ADDR_WIDTH.
- AxSIZE other than log2(STRB_WIDTH) sets SLVERR; data is still transferred at full width.
- Simultaneous read and write to the same word in one cycle: read returns old data (read-first).

Optional Feature:
- AXI_RAM_STALL_EN
- Defined: a 16-bit LFSR (seed 16'hACE1, reset by rst) deasserts AWREADY, WREADY and ARREADY in cycles where lfsr[0]==1. It also delays entry to W_RESP/R_DATA by one cycle when lfsr[1]==1.
- VALID is never deasserted once asserted.
- Undefined: no stalls; timing exactly as above.

Decomposition:
- Package axi_ram_pkg holds:
  - BURST_FIXED/INCR/WRAP constants (2'b00/01/10).
  - RESP_OKAY/SLVERR constants.
  - wr_state_t and rd_state_t enums.
- Sub-module axi_ram_mem: simple dual-port synchronous RAM with one byte-enabled write port and one read port, 1-cycle read latency, read-first.

Test Plan:
- INCR write AWADDR=0x100, AWLEN=3, WSTRB=all 1s, data 0x..01..04; then read the same -> BRESP=OKAY, BID=AWID; four R beats match, RLAST on the 4th, first RVALID 2 cycles after the AR handshake.
- Partial strobe: write 0xFFFF...F to 0x200, then WSTRB=16'h00F0 with 0 -> readback has bytes 4-7 zero, all others 0xFF.
- FIXED burst AWADDR=0x300, AWLEN=2, data A, B, C -> only C stored at 0x300; 0x310 unchanged.
- Out-of-range: AWADDR=0x1_0000 with MEM_ADDR_BITS=16 -> BRESP=SLVERR, no RAM change; read of the same address -> RDATA=0, RRESP=SLVERR.
- WLAST early on beat 1 of AWLEN=3 -> burst still takes 4 beats, BRESP=SLVERR; RREADY toggled 1/0 during a 16-beat read -> data order intact, no beat lost or duplicated.
- rst pulsed mid-read burst -> next cycle RVALID=0, ARREADY=1 after release; a new read returns the previously written data.
